// File: rtl/alu_share_if.sv
// rtl/alu_share_if.sv - request, ALU and response signal bundle for alu_share_ctrl
interface alu_share_if #(
  parameter int DW = 16
);
  logic          req0_valid;
  logic          req0_ready;
  logic [3:0]    req0_op;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req0_cin;

  logic          req1_valid;
  logic          req1_ready;
  logic [3:0]    req1_op;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic          req1_cin;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_cin;
  logic [9:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_cout;
  logic          alu_zout;

  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_cout;
  logic          rsp_zout;
  logic          rsp_err;

  // controller side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
    input  alu_out, alu_cout, alu_zout,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_cin, alu_sel,
    output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zout, rsp_err
  );

  // requesters plus ALU side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_cin,
    output req1_valid, req1_op, req1_a, req1_b, req1_cin,
    output alu_out, alu_cout, alu_zout,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_cin, alu_sel,
    input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_zout, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - two-port arbiter and sequencer for the shared SAYEH ALU
// ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module alu_share_ctrl #(
  parameter int DW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_share_if.slave  bus,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          any_valid;
  logic          grant1;
  logic          accept;
  logic          legal;
  logic [3:0]    op_s;
  logic [DW-1:0] a_s;
  logic [DW-1:0] b_s;
  logic          cin_s;
  logic [9:0]    sel_dec;

  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_b_q;
  logic          alu_cin_q;
  logic [9:0]    alu_sel_q;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_cout_q;
  logic          rsp_zout_q;
  logic          rsp_err_q;

  assign any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ARB_RR_EN
  // last_q holds the port granted most recently; reset to 1 so port 0 wins first
  logic last_q;

  always_comb begin
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant1;
    end
  end
`else
  always_comb begin
    grant1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  always_comb begin
    op_s    = grant1 ? bus.req1_op  : bus.req0_op;
    a_s     = grant1 ? bus.req1_a   : bus.req0_a;
    b_s     = grant1 ? bus.req1_b   : bus.req0_b;
    cin_s   = grant1 ? bus.req1_cin : bus.req0_cin;
    legal   = (op_s <= 4'd9);
    sel_dec = '0;
    for (int i = 0; i < 10; i++) begin
      if (op_s == 4'(9 - i)) begin
        sel_dec[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept    = 1'b1;
          state_nxt = legal ? EXEC : RESP;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // illegal ops skip EXEC and load the error response directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
      alu_sel_q  <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
      rsp_zout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      rsp_id_q <= grant1;
      if (legal) begin
        alu_a_q   <= a_s;
        alu_b_q   <= b_s;
        alu_cin_q <= cin_s;
        alu_sel_q <= sel_dec;
      end else begin
        rsp_data_q <= '0;
        rsp_cout_q <= 1'b0;
        rsp_zout_q <= 1'b0;
        rsp_err_q  <= 1'b1;
      end
    end else if (state == EXEC) begin
      rsp_data_q <= bus.alu_out;
      rsp_cout_q <= bus.alu_cout;
      rsp_zout_q <= bus.alu_zout;
      rsp_err_q  <= 1'b0;
      alu_sel_q  <= '0;
    end
  end

  assign bus.req0_ready = accept & ~grant1 & rst_n;
  assign bus.req1_ready = accept &  grant1 & rst_n;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cin    = alu_cin_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_zout   = rsp_zout_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - randomized and directed bench for alu_share_ctrl
// Response timing, arbitration and ALU results come from a timestamp model.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  alu_share_if #(.DW(16)) bus ();

  alu_share_ctrl #(.DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Behavioural SAYEH ALU: {cout, zout, result}
  function automatic logic [17:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    logic        z;
    c = 1'b0;
    r = 16'hDEAD;
    case (op)
      4'd0: r = b;
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = ~b;
      4'd4: begin r = b << 1; c = b[15]; end
      4'd5: begin r = b >> 1; c = b[0]; end
      4'd6: begin w = 17'(a) + 17'(b) + 17'(cin); r = w[15:0]; c = w[16]; end
      4'd7: begin w = 17'(a) - 17'(b) - 17'(cin); r = w[15:0]; c = w[16]; end
      4'd8: r = 16'(a[7:0]) * 16'(b[7:0]);
      4'd9: begin r = 16'h0000; c = (a > b); end
      default: r = 16'hDEAD;
    endcase
    z = (op == 4'd9) ? (a == b) : (r == 16'h0000);
    return {c, z, r};
  endfunction

  // ALU stub driven from the controller's registered select
  always_comb begin
    logic [3:0]  op;
    int          n;
    logic [17:0] res;
    op = 4'd15;
    n  = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.alu_sel[i]) begin
        op = 4'(9 - i);
        n++;
      end
    end
    res = (n == 1) ? alu_fn(op, bus.alu_a, bus.alu_b, bus.alu_cin) : 18'h0BEEF;
    bus.alu_out  = res[15:0];
    bus.alu_zout = res[16];
    bus.alu_cout = res[17];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + compare process ----------------
  int          cyc = 0;
  int          acc_cyc = -10;
  int          resp_cyc = -10;
  int          free_cyc = 0;
  logic        last_win = 1'b1;
  logic        p_legal = 1'b0;
  logic [3:0]  p_op;
  logic [15:0] p_a, p_b;
  logic        p_cin, p_id;
  logic [17:0] p_res;
  logic [15:0] h_data = '0;
  logic        h_cout = 1'b0, h_zout = 1'b0, h_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_alu_a", bus.alu_a, 0);
      check("rst_alu_b", bus.alu_b, 0);
      check("rst_alu_cin", bus.alu_cin, 0);
      check("rst_alu_sel", bus.alu_sel, 0);
      check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_zout, bus.rsp_err}, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_busy", busy, 0);
      acc_cyc = cyc - 10; resp_cyc = cyc - 10; free_cyc = cyc;
      last_win = 1'b1; p_legal = 1'b0;
      h_data = '0; h_cout = 0; h_zout = 0; h_err = 0;
    end else begin
      logic v0, v1, win, e_r0, e_r1, free;
      cyc++;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      free = (cyc >= free_cyc);
`ifdef ARB_RR_EN
      win = (v0 && v1) ? ~last_win : v1;
`else
      win = (v0 && v1) ? 1'b0 : v1;
`endif
      e_r0 = free && (v0 || v1) && !win;
      e_r1 = free && (v0 || v1) && win;
      check("ready0", bus.req0_ready, e_r0);
      check("ready1", bus.req1_ready, e_r1);
      check("busy", busy, (cyc > acc_cyc) && (cyc < free_cyc));
      if (p_legal && cyc == acc_cyc + 1) begin
        check("alu_sel", bus.alu_sel, 10'b1 << (9 - p_op));
        check("alu_a", bus.alu_a, p_a);
        check("alu_b", bus.alu_b, p_b);
        check("alu_cin", bus.alu_cin, p_cin);
      end else begin
        check("alu_sel_idle", bus.alu_sel, 0);
      end
      if (cyc == resp_cyc) begin
        h_data = p_res[15:0];
        h_zout = p_res[16];
        h_cout = p_res[17];
        h_err  = !p_legal;
        check("rsp_id", bus.rsp_id, p_id);
      end
      check("rsp_valid", bus.rsp_valid, cyc == resp_cyc);
      check("rsp_data", bus.rsp_data, h_data);
      check("rsp_flags", {bus.rsp_cout, bus.rsp_zout, bus.rsp_err}, {h_cout, h_zout, h_err});
      if (e_r0 || e_r1) begin
        p_id    = win;
        p_op    = win ? bus.req1_op  : bus.req0_op;
        p_a     = win ? bus.req1_a   : bus.req0_a;
        p_b     = win ? bus.req1_b   : bus.req0_b;
        p_cin   = win ? bus.req1_cin : bus.req0_cin;
        p_legal = (p_op < 10);
        p_res   = p_legal ? alu_fn(p_op, p_a, p_b, p_cin) : 18'h0;
        acc_cyc  = cyc;
        resp_cyc = cyc + (p_legal ? 2 : 1);
        free_cyc = resp_cyc + 1;
        last_win = win;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_req(input int p, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic cin);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end
  endtask

  // returns negedges waited until ready; drops valid just after the accepting edge
  task automatic wait_accept(input int p, output int n);
    logic r;
    n = 0;
    r = 1'b0;
    while (!r && n < 12) begin
      @(negedge clk);
      n++;
      r = (p == 0) ? bus.req0_ready : bus.req1_ready;
    end
    if (!r) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (p == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  initial begin
    int n;
    int rv_cnt;
    logic [5:0] ids;
    logic [5:0] exp_ids;
    logic r0, r1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // AaddB overflow on port 0
    set_req(0, 1, 4'd6, 16'hFFFF, 16'h0001, 1'b0);
    wait_accept(0, n);
    @(negedge clk);
    check("addb_sel", bus.alu_sel, 10'b0000001000);
    @(negedge clk);
    check("addb_valid", bus.rsp_valid, 1);
    check("addb_id", bus.rsp_id, 0);
    check("addb_data", bus.rsp_data, 16'h0000);
    check("addb_cz", {bus.rsp_cout, bus.rsp_zout}, 2'b11);

    // AmulB on port 1
    set_req(1, 1, 4'd8, 16'h0012, 16'h0010, 1'b0);
    wait_accept(1, n);
    repeat (2) @(negedge clk);
    check("mulb_valid", bus.rsp_valid, 1);
    check("mulb_id", bus.rsp_id, 1);
    check("mulb_data", bus.rsp_data, 16'h0120);
    check("mulb_z", bus.rsp_zout, 0);

    // illegal op 12
    @(posedge clk); #1;
    set_req(0, 1, 4'd12, 16'h1234, 16'h5678, 1'b1);
    wait_accept(0, n);
    @(negedge clk);
    check("ill_valid", bus.rsp_valid, 1);
    check("ill_err", bus.rsp_err, 1);
    check("ill_data", bus.rsp_data, 0);
    check("ill_sel", bus.alu_sel, 0);

    // request raised during EXEC waits until IDLE
    @(posedge clk); #1;
    set_req(0, 1, 4'd1, 16'h00F0, 16'h0FF0, 1'b0);
    wait_accept(0, n);
    set_req(1, 1, 4'd7, 16'h0005, 16'h0007, 1'b0);
    wait_accept(1, n);
    check("exec_raise_gap", n, 3);
    repeat (3) @(posedge clk); #1;

    // both ports continuously valid with AorB
    set_req(0, 1, 4'd2, 16'h0F00, 16'h00F0, 1'b0);
    set_req(1, 1, 4'd2, 16'hA000, 16'h000A, 1'b1);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.rsp_valid && n < 12);
      if (!bus.rsp_valid) check("tie_timeout", 0, 1);
      ids[k] = bus.rsp_id;
    end
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
`ifdef ARB_RR_EN
    exp_ids = 6'b101010;
`else
    exp_ids = 6'b000000;
`endif
    check("tie_id_seq", ids, exp_ids);
    repeat (3) @(posedge clk);

    // randomized traffic with withdrawals and illegal ops
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      @(posedge clk); #1;
      if (bus.req0_valid && (r0 || $urandom_range(0, 19) == 0)) bus.req0_valid = 1'b0;
      if (bus.req1_valid && (r1 || $urandom_range(0, 19) == 0)) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && $urandom_range(0, 2) == 0)
        set_req(0, 1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom));
      if (!bus.req1_valid && $urandom_range(0, 2) == 0)
        set_req(1, 1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk); #1;

    // reset asserted mid-EXEC
    set_req(0, 1, 4'd6, 16'h1111, 16'h2222, 1'b1);
    wait_accept(0, n);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", bus.alu_sel, 0);
    check("async_rst_a", bus.alu_a, 0);
    check("async_rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rv_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) rv_cnt++;
    end
    check("no_rsp_after_rst", rv_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
